sram_access_arbiter: RTL and testbench

//  Shares the single off-chip SRAM between two requesters: port 0 = CPU (MAR/MDR path,

---
 rtl/sram_access_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
//
// Shares one off-chip SRAM between two requesters: port 0 is the CPU memory path and
// port 1 is the program loader / debug DMA. Requests are arbitrated round-robin. Each
// granted access is a fixed ACCESS_CYCLES-long OE (read) or WE (write) window, then one
// DONE cycle that pulses done for the granted port. DONE is followed by one IDLE cycle
// for bus turnaround, so accesses are never issued back to back.
//
// Ports
//   Clk            system clock, rising edge
//   Reset          synchronous reset, active low
//   req0/req1      access request, port 0 / port 1
//   we0/we1        1 = write, 0 = read, sampled with req
//   addr0/addr1    word address
//   wdata0/wdata1  write data
//   done0/done1    one-cycle completion pulse to the granted port
//   rdata          read data, valid while done0|done1 and held afterwards
//   busy           high while an access is in progress (ACCESS or DONE)
//   sram_addr      address to the SRAM pin wrapper
//   sram_wdata     write data to the SRAM pin wrapper
//   sram_rdata     read data from the SRAM pin wrapper
//   sram_oe        SRAM output enable, active high
//   sram_we        SRAM write enable, active high
//
// ACCESS_CYCLES must lie in 1..15; the window counter is 4 bits wide.

module sram_access_arbiter #(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_oe,
  output logic              sram_we
);

  // Counter value of the final cycle of the OE/WE window.
  localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                gnt_q;       // port owning the current access
  logic                last_gnt_q;  // port granted most recently, for round-robin
  logic                we_q;        // latched direction of the current access
  logic                done0_q;
  logic                done1_q;
  logic                busy_q;
  logic                oe_q;
  logic                wen_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  // Arbitration and request selection.
  logic                pick;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      // Contention: the port that did not win last time goes next.
      pick = ~last_gnt_q;
    end else begin
      pick = req1;
    end
    sel_we    = pick ? we1    : we0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

  // Single sequential block: state, counter and every output are registered here.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;  // port 0 wins the first tie after reset
      we_q       <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      oe_q       <= 1'b0;
      wen_q      <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            state_q    <= StAccess;
            cnt_q      <= 4'd0;
            gnt_q      <= pick;
            last_gnt_q <= pick;
            // Inputs are latched here; later changes by the requester are ignored.
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            oe_q       <= ~sel_we;
            wen_q      <= sel_we;
            busy_q     <= 1'b1;
          end
        end

        StAccess: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            oe_q    <= 1'b0;
            wen_q   <= 1'b0;
            // Read data is captured at the edge that closes the OE window.
            if (!we_q) begin
              rdata_q <= sram_rdata;
            end
            done0_q <= ~gnt_q;
            done1_q <= gnt_q;
          end
        end

        StDone: begin
          // Unconditional return to idle gives one turnaround cycle between accesses.
          state_q <= StIdle;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          oe_q    <= 1'b0;
          wen_q   <= 1'b0;
        end
      endcase
    end
  end

  assign done0      = done0_q;
  assign done1      = done1_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_oe    = oe_q;
  assign sram_we    = wen_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
module tb_sram_access_arbiter;

  localparam int AC = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [19:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        done0, done1, busy, sram_oe, sram_we;
  logic [15:0] rdata, sram_wdata;
  logic [15:0] sram_rdata = '0;
  logic [19:0] sram_addr;

  // Extra builds with the extreme window lengths.
  logic        xreq1 = 1'b0, xreq15 = 1'b0;
  logic [19:0] xaddr = '0;
  logic        x1_d0, x1_d1, x1_busy, x1_oe, x1_we;
  logic        x15_d0, x15_d1, x15_busy, x15_oe, x15_we;
  logic [15:0] x1_rdata, x1_wdata, x15_rdata, x15_wdata;
  logic [19:0] x1_addr, x15_addr;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] sram_mem [logic [19:0]];
  logic [15:0] ref_mem  [logic [19:0]];

  always #5 Clk = ~Clk;

  // SRAM model: read data presented and writes committed on the falling edge.
  always @(negedge Clk) begin
    if (sram_we) sram_mem[sram_addr] = sram_wdata;
    sram_rdata <= (sram_oe && sram_mem.exists(sram_addr)) ? sram_mem[sram_addr] : 16'h0;
  end

  sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(AC)) dut (
    .Clk(Clk), .Reset(Reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .busy(busy), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_oe(sram_oe), .sram_we(sram_we)
  );

  sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(1)) dut_ac1 (
    .Clk(Clk), .Reset(Reset), .req0(xreq1), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(xaddr), .addr1(20'h0), .wdata0(16'h0), .wdata1(16'h0),
    .done0(x1_d0), .done1(x1_d1), .rdata(x1_rdata), .busy(x1_busy), .sram_addr(x1_addr),
    .sram_wdata(x1_wdata), .sram_rdata(16'h5A5A), .sram_oe(x1_oe), .sram_we(x1_we)
  );

  sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(15)) dut_ac15 (
    .Clk(Clk), .Reset(Reset), .req0(xreq15), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(xaddr), .addr1(20'h0), .wdata0(16'h0), .wdata1(16'h0),
    .done0(x15_d0), .done1(x15_d1), .rdata(x15_rdata), .busy(x15_busy), .sram_addr(x15_addr),
    .sram_wdata(x15_wdata), .sram_rdata(16'hC3C3), .sram_oe(x15_oe), .sram_we(x15_we)
  );

  // Drives a reset and leaves the bench at a falling edge with Reset released.
  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; xreq1 = 1'b0; xreq15 = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    vectors++;
    if ({done0, done1, busy, sram_oe, sram_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {done0, done1, busy, sram_oe, sram_we});
    end
    vectors++;
    if ({rdata, sram_addr, sram_wdata} !== 52'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want zeros",
               rdata, sram_addr, sram_wdata);
    end
    Reset = 1'b1;
  endtask

  task automatic test_read();
    logic [4:0] exp_v;
    sram_mem[20'h00012] = 16'hBEEF;
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00012;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      exp_v = {i < 3, 1'b0, i == 3, 1'b0, i <= 3};
      vectors++;
      if ({sram_oe, sram_we, done0, done1, busy} !== exp_v) begin
        errors++;
        $display("FAIL read_seq cyc%0d: got %b want %b", i,
                 {sram_oe, sram_we, done0, done1, busy}, exp_v);
      end
      if (i == 3) begin
        vectors++;
        if (rdata !== 16'hBEEF) begin
          errors++;
          $display("FAIL read_data: got %h want beef", rdata);
        end
        req0 = 1'b0;
      end
    end
  endtask

  task automatic test_write();
    logic [4:0] exp_v;
    req1 = 1'b1; we1 = 1'b1; addr1 = 20'hFFFFF; wdata1 = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      exp_v = {1'b0, i < 3, 1'b0, i == 3, i <= 3};
      vectors++;
      if ({sram_oe, sram_we, done0, done1, busy} !== exp_v) begin
        errors++;
        $display("FAIL write_seq cyc%0d: got %b want %b", i,
                 {sram_oe, sram_we, done0, done1, busy}, exp_v);
      end
      if (i < 3) begin
        vectors++;
        if ({sram_addr, sram_wdata} !== {20'hFFFFF, 16'h1234}) begin
          errors++;
          $display("FAIL write_bus cyc%0d: got %h/%h want fffff/1234", i, sram_addr, sram_wdata);
        end
      end
      if (i == 3) begin
        vectors++;
        if (rdata !== 16'hBEEF) begin
          errors++;
          $display("FAIL write_rdata_kept: got %h want beef", rdata);
        end
        req1 = 1'b0;
      end
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'hFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (i == 3) begin
        vectors++;
        if ({done0, done1, rdata} !== {2'b10, 16'h1234}) begin
          errors++;
          $display("FAIL readback: got done=%b%b rdata=%h want 10/1234", done0, done1, rdata);
        end
        req0 = 1'b0;
      end
    end
  endtask

  task automatic test_tie();
    logic       port;
    logic [1:0] exp_d;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00100;
    req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00200;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      port  = ((i / 5) % 2) == 1;
      exp_d = (i % 5 == 3) ? (port ? 2'b01 : 2'b10) : 2'b00;
      vectors++;
      if ({done0, done1} !== exp_d) begin
        errors++;
        $display("FAIL tie_done cyc%0d: got %b%b want %b", i, done0, done1, exp_d);
      end
      if (i % 5 == 1) begin
        vectors++;
        if (sram_addr !== (port ? 20'h00200 : 20'h00100)) begin
          errors++;
          $display("FAIL tie_addr cyc%0d: got %h want port %0d address", i, sram_addr, port);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_latch();
    int n_done = 0;
    sram_mem[20'h00010] = 16'h0A0A;
    sram_mem[20'h00020] = 16'h2020;
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00010;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (done0) n_done++;
      if (i <= 3) begin
        vectors++;
        if ({sram_addr, sram_oe, sram_we} !== {20'h00010, i < 3, 1'b0}) begin
          errors++;
          $display("FAIL latch_bus cyc%0d: got addr=%h oe=%b we=%b want 00010/%b/0",
                   i, sram_addr, sram_oe, sram_we, i < 3);
        end
      end
      if (i == 0) begin
        addr0 = 20'h00020; we0 = 1'b1; wdata0 = 16'hFFFF; req0 = 1'b0;
      end
    end
    vectors++;
    if (n_done != 1 || rdata !== 16'h0A0A) begin
      errors++;
      $display("FAIL latch_done: got %0d pulses rdata=%h want 1/0a0a", n_done, rdata);
    end
  endtask

  task automatic test_reset_mid();
    sram_mem[20'h00044] = 16'h4444;
    req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00033; wdata0 = 16'h7777;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (i < 2) begin
        vectors++;
        if (sram_we !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_we cyc%0d: got %b want 1", i, sram_we);
        end
      end else begin
        vectors++;
        if ({sram_we, sram_oe, busy, done0, done1} !== 5'b0) begin
          errors++;
          $display("FAIL rstmid_abort cyc%0d: got %b want 00000", i,
                   {sram_we, sram_oe, busy, done0, done1});
        end
      end
      if (i == 0) req0 = 1'b0;
      if (i == 1) Reset = 1'b0;
      if (i == 2) begin
        vectors++;
        if (rdata !== 16'h0) begin
          errors++;
          $display("FAIL rstmid_rdata: got %h want 0000", rdata);
        end
        Reset = 1'b1;
      end
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00044;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      vectors++;
      if ({sram_oe, done1} !== {i < 3, i == 3}) begin
        errors++;
        $display("FAIL rstmid_after cyc%0d: got %b%b want %b%b", i, sram_oe, done1, i < 3, i == 3);
      end
      if (i == 3) begin
        vectors++;
        if (rdata !== 16'h4444) begin
          errors++;
          $display("FAIL rstmid_after_data: got %h want 4444", rdata);
        end
        req1 = 1'b0;
      end
    end
  endtask

  task automatic test_access_extremes();
    xreq1 = 1'b1; xreq15 = 1'b1; xaddr = 20'h00005;
    for (int i = 0; i < 17; i++) begin
      @(negedge Clk);
      vectors++;
      if ({x1_oe, x1_we, x1_d0, x1_d1, x1_busy} !== {i == 0, 1'b0, i == 1, 1'b0, i <= 1}) begin
        errors++;
        $display("FAIL ac1_seq cyc%0d: got %b", i, {x1_oe, x1_we, x1_d0, x1_d1, x1_busy});
      end
      vectors++;
      if ({x15_oe, x15_we, x15_d0, x15_d1, x15_busy} !== {i < 15, 1'b0, i == 15, 1'b0, i <= 15})
      begin
        errors++;
        $display("FAIL ac15_seq cyc%0d: got %b", i, {x15_oe, x15_we, x15_d0, x15_d1, x15_busy});
      end
      if (i == 0) begin
        vectors++;
        if ({x1_addr, x1_wdata, x15_addr, x15_wdata} !== {20'h5, 16'h0, 20'h5, 16'h0}) begin
          errors++;
          $display("FAIL ac_bus: got %h %h %h %h want 00005 0000 00005 0000",
                   x1_addr, x1_wdata, x15_addr, x15_wdata);
        end
      end
      if (i == 1) begin
        vectors++;
        if (x1_rdata !== 16'h5A5A) begin
          errors++;
          $display("FAIL ac1_data: got %h want 5a5a", x1_rdata);
        end
        xreq1 = 1'b0;
      end
      if (i == 15) begin
        vectors++;
        if ({x15_rdata, x15_addr} !== {16'hC3C3, 20'h5}) begin
          errors++;
          $display("FAIL ac15_data: got %h/%h want c3c3/00005", x15_rdata, x15_addr);
        end
        xreq15 = 1'b0;
      end
    end
  endtask

  // Random traffic against a transaction-level model: each grant edge g defines an
  // OE/WE window over the cycles after edges g..g+AC-1 and a done pulse after edge g+AC.
  task automatic test_random(input int n);
    logic        rq[2], wq[2];
    logic [19:0] aq[2];
    logic [15:0] dq[2];
    int          e, g, next_ok;
    logic        act, gp, gwe, last, in_acc, in_done, mine_done, mine_acc;
    logic [19:0] ga;
    logic [15:0] gd, g_rdata, m_rdata;
    logic [4:0]  exp_v;
    sram_mem.delete();
    ref_mem.delete();
    do_reset();
    e = 0; g = 0; next_ok = 1; act = 1'b0; last = 1'b1; gp = 1'b0; gwe = 1'b0;
    ga = '0; gd = '0; g_rdata = '0; m_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; wq[p] = 1'b0; aq[p] = '0; dq[p] = '0;
    end
    for (int it = 0; it < n; it++) begin
      @(negedge Clk);
      in_acc  = act && e >= g && e <= g + AC - 1;
      in_done = act && e == g + AC;
      if (in_done && !gwe) m_rdata = g_rdata;
      exp_v = {in_acc || in_done, in_acc && !gwe, in_acc && gwe, in_done && !gp, in_done && gp};
      vectors++;
      if ({busy, sram_oe, sram_we, done0, done1} !== exp_v) begin
        errors++;
        $display("FAIL rand_ctrl it%0d: got %b want %b", it,
                 {busy, sram_oe, sram_we, done0, done1}, exp_v);
      end
      vectors++;
      if (rdata !== m_rdata) begin
        errors++;
        $display("FAIL rand_rdata it%0d: got %h want %h", it, rdata, m_rdata);
      end
      if (in_acc || in_done) begin
        vectors++;
        if (sram_addr !== ga) begin
          errors++;
          $display("FAIL rand_addr it%0d: got %h want %h", it, sram_addr, ga);
        end
      end
      if (in_acc && gwe) begin
        vectors++;
        if (sram_wdata !== gd) begin
          errors++;
          $display("FAIL rand_wdata it%0d: got %h want %h", it, sram_wdata, gd);
        end
      end
      for (int p = 0; p < 2; p++) begin
        mine_done = in_done && (gp == p[0]);
        mine_acc  = in_acc && (gp == p[0]);
        if (rq[p] && mine_done) begin
          rq[p] = ($urandom_range(0, 3) == 0);
          wq[p] = 1'($urandom_range(0, 1));
          aq[p] = 20'($urandom_range(0, 7) * 32'h11111);
          dq[p] = 16'($urandom);
        end else if (rq[p] && mine_acc && $urandom_range(0, 3) == 0) begin
          wq[p] = 1'($urandom_range(0, 1));
          aq[p] = 20'($urandom);
          dq[p] = 16'($urandom);
          rq[p] = 1'($urandom_range(0, 1));
        end else if (!rq[p] && $urandom_range(0, 2) == 0) begin
          rq[p] = 1'b1;
          wq[p] = 1'($urandom_range(0, 1));
          aq[p] = 20'($urandom_range(0, 7) * 32'h11111);
          dq[p] = 16'($urandom);
        end
      end
      req0 = rq[0]; we0 = wq[0]; addr0 = aq[0]; wdata0 = dq[0];
      req1 = rq[1]; we1 = wq[1]; addr1 = aq[1]; wdata1 = dq[1];
      Reset = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      @(posedge Clk);
      e++;
      if (!Reset) begin
        // A write cut short by reset leaves that location undefined.
        if (act && gwe && e - 1 >= g && e - 1 <= g + AC - 1) begin
          if (ref_mem.exists(ga)) ref_mem.delete(ga);
          if (sram_mem.exists(ga)) sram_mem.delete(ga);
        end
        act = 1'b0; last = 1'b1; m_rdata = '0; next_ok = e + 1;
      end else if (e >= next_ok && (req0 || req1)) begin
        gp   = (req0 && req1) ? ~last : req1;
        last = gp;
        g    = e;
        act  = 1'b1;
        gwe  = gp ? we1 : we0;
        ga   = gp ? addr1 : addr0;
        gd   = gp ? wdata1 : wdata0;
        if (gwe) ref_mem[ga] = gd;
        else g_rdata = ref_mem.exists(ga) ? ref_mem[ga] : 16'h0;
        next_ok = e + AC + 2;
      end
    end
    @(negedge Clk);
    Reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_latch();
    test_reset_mid();
    test_access_extremes();
    test_random(800);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
